// File: rtl/mem_arb_pkg.sv
// Shared constants for the fetch/load-store memory arbiter:
// FSM state encodings and grant-owner identifiers.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/arb_timer.sv
// Counts granted cycles and flags when the no-ack limit has been reached.
module arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic a_clk,
  input  logic a_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The last granted cycle is the one in which the count equals TIMEOUT-1.
  assign o_expired = (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction
// fetch and load/store, with fetch squashing on redirect and a no-ack timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   a_clk,
  input  logic                   a_rst,
  input  logic                   i_syn_i,
  input  logic [A_WIDTH-1:0]     i_addr_i,
  output logic [D_WIDTH-1:0]     o_data_i,
  output logic                   o_ack_i,
  input  logic                   i_flush,
  input  logic                   i_syn_d,
  input  logic                   i_we_d,
  input  logic [A_WIDTH-1:0]     i_addr_d,
  input  logic [D_WIDTH-1:0]     i_wdata_d,
  input  logic [D_WIDTH/8-1:0]   i_sel_d,
  output logic [D_WIDTH-1:0]     o_rdata_d,
  output logic                   o_ack_d,
  output logic                   o_mem_syn,
  output logic                   o_mem_we,
  output logic [A_WIDTH-1:0]     o_mem_addr,
  output logic [D_WIDTH-1:0]     o_mem_wdata,
  output logic [D_WIDTH/8-1:0]   o_mem_sel,
  input  logic [D_WIDTH-1:0]     i_mem_rdata,
  input  logic                   i_mem_ack,
  output logic                   o_owner,
  output logic                   o_err
);

  localparam int S_WIDTH = D_WIDTH / 8;

  logic [1:0]         state_q, state_d;
  logic               last_owner_q, last_owner_d;
  logic               squash_q, squash_d;
  logic               mem_syn_q, mem_syn_d;
  logic               mem_we_q, mem_we_d;
  logic [A_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [D_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [S_WIDTH-1:0] mem_sel_q, mem_sel_d;
  logic               owner_q, owner_d;
  logic [D_WIDTH-1:0] data_i_q, data_i_d;
  logic               ack_i_q, ack_i_d;
  logic [D_WIDTH-1:0] rdata_d_q, rdata_d_d;
  logic               ack_d_q, ack_d_d;
  logic               err_q, err_d;

  logic               elig_i;
  logic               elig_d;
  logic               pick_d;
  logic               granted;
  logic               done;
  logic [D_WIDTH-1:0] rsp_data;
  logic               tmr_clr;
  logic               tmr_inc;
  logic               tmr_expired;

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .a_clk     (a_clk),
    .a_rst     (a_rst),
    .i_clr     (tmr_clr),
    .i_inc     (tmr_inc),
    .o_expired (tmr_expired)
  );

  assign elig_i   = i_syn_i & ~i_flush;
  assign elig_d   = i_syn_d;
  // Data wins when it is alone, or when both compete and fetch went last.
  assign pick_d   = elig_d & (~elig_i | (last_owner_q == OWNER_I));
  assign granted  = (state_q == ST_GNT_I) | (state_q == ST_GNT_D);
  // An ack in the expiring cycle still counts as a normal completion.
  assign done     = granted & (i_mem_ack | tmr_expired);
  assign rsp_data = i_mem_ack ? i_mem_rdata : '0;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    squash_d     = squash_q;
    mem_syn_d    = mem_syn_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_sel_d    = mem_sel_q;
    owner_d      = owner_q;
    data_i_d     = data_i_q;
    rdata_d_d    = rdata_d_q;
    ack_i_d      = 1'b0;
    ack_d_d      = 1'b0;
    err_d        = 1'b0;
    tmr_clr      = 1'b0;
    tmr_inc      = granted & ~done;

    case (state_q)
      ST_IDLE: begin
        if (pick_d) begin
          state_d      = ST_GNT_D;
          owner_d      = OWNER_D;
          last_owner_d = OWNER_D;
          mem_syn_d    = 1'b1;
          mem_we_d     = i_we_d;
          mem_addr_d   = i_addr_d;
          mem_wdata_d  = i_wdata_d;
          mem_sel_d    = i_sel_d;
        end else if (elig_i) begin
          state_d      = ST_GNT_I;
          owner_d      = OWNER_I;
          last_owner_d = OWNER_I;
          mem_syn_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = i_addr_i;
          mem_sel_d    = '1;
        end
      end
      ST_GNT_I: begin
        if (i_flush) begin
          squash_d = 1'b1;
        end
        if (done) begin
          state_d   = ST_RESP;
          mem_syn_d = 1'b0;
          data_i_d  = rsp_data;
          err_d     = ~i_mem_ack;
          ack_i_d   = ~(squash_q | i_flush);
        end
      end
      ST_GNT_D: begin
        if (done) begin
          state_d   = ST_RESP;
          mem_syn_d = 1'b0;
          rdata_d_d = rsp_data;
          err_d     = ~i_mem_ack;
          ack_d_d   = 1'b1;
        end
      end
      default: begin
        // The completion pulse is visible during this cycle, so requesters
        // drop syn before the next IDLE sample and no double grant occurs.
        state_d  = ST_IDLE;
        squash_d = 1'b0;
        tmr_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_D;
      squash_q     <= 1'b0;
      mem_syn_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_sel_q    <= '0;
      owner_q      <= 1'b0;
      data_i_q     <= '0;
      ack_i_q      <= 1'b0;
      rdata_d_q    <= '0;
      ack_d_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      squash_q     <= squash_d;
      mem_syn_q    <= mem_syn_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_sel_q    <= mem_sel_d;
      owner_q      <= owner_d;
      data_i_q     <= data_i_d;
      ack_i_q      <= ack_i_d;
      rdata_d_q    <= rdata_d_d;
      ack_d_q      <= ack_d_d;
      err_q        <= err_d;
    end
  end

  assign o_data_i    = data_i_q;
  assign o_ack_i     = ack_i_q;
  assign o_rdata_d   = rdata_d_q;
  assign o_ack_d     = ack_d_q;
  assign o_mem_syn   = mem_syn_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_sel   = mem_sel_q;
  assign o_owner     = owner_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// rounds checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        a_clk, a_rst;
  logic        i_syn_i, i_flush, i_syn_d, i_we_d, i_mem_ack;
  logic [31:0] i_addr_i, i_addr_d, i_wdata_d, i_mem_rdata;
  logic [3:0]  i_sel_d;
  logic [31:0] o_data_i, o_rdata_d, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_sel;
  logic        o_ack_i, o_ack_d, o_mem_syn, o_mem_we, o_owner, o_err;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.A_WIDTH(32), .D_WIDTH(32), .TIMEOUT(TO)) dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .i_syn_i(i_syn_i), .i_addr_i(i_addr_i), .o_data_i(o_data_i), .o_ack_i(o_ack_i),
    .i_flush(i_flush),
    .i_syn_d(i_syn_d), .i_we_d(i_we_d), .i_addr_d(i_addr_d), .i_wdata_d(i_wdata_d),
    .i_sel_d(i_sel_d), .o_rdata_d(o_rdata_d), .o_ack_d(o_ack_d),
    .o_mem_syn(o_mem_syn), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_sel(o_mem_sel),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_owner(o_owner), .o_err(o_err)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  typedef struct {
    bit          owner;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } req_t;

  req_t        log_q[$];
  logic [31:0] mem_dev[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          forced_ack_at = 0;
  int          cur_ack_at = 0;
  bit          late_ack = 1'b0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rmem(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Memory/bus responder: acks on the cur_ack_at-th granted cycle.
  bit          rsp_in_txn;
  int          rsp_k;
  bit          rsp_ack;
  logic [31:0] rsp_rd;
  initial begin
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'h0;
    rsp_in_txn  = 1'b0;
    rsp_k       = 0;
    forever begin
      @(negedge a_clk);
      rsp_ack = 1'b0;
      rsp_rd  = 32'h0;
      if (o_mem_syn) begin
        if (!rsp_in_txn) begin
          rsp_in_txn = 1'b1;
          rsp_k      = 0;
          cur_ack_at = (forced_ack_at != 0) ? forced_ack_at : $urandom_range(1, TO + 1);
          log_q.push_back('{o_owner, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_sel});
        end
        rsp_k++;
        if (rsp_k == cur_ack_at) begin
          rsp_ack = 1'b1;
          rsp_rd  = mem_dev.exists(o_mem_addr) ? mem_dev[o_mem_addr] : dflt(o_mem_addr);
          if (o_mem_we) mem_dev[o_mem_addr] = merge(rsp_rd, o_mem_wdata, o_mem_sel);
        end
      end else begin
        rsp_in_txn = 1'b0;
      end
      i_mem_ack   = rsp_ack | late_ack;
      i_mem_rdata = rsp_ack ? rsp_rd : (late_ack ? 32'hBAD0_BAD0 : 32'h0);
    end
  end

  task automatic apply_reset();
    @(negedge a_clk);
    a_rst = 1'b1;
    i_syn_i = 0; i_addr_i = 0; i_flush = 0;
    i_syn_d = 0; i_we_d = 0; i_addr_d = 0; i_wdata_d = 0; i_sel_d = 0;
    forced_ack_at = 0;
    @(negedge a_clk);
    @(negedge a_clk);
    a_rst = 1'b0;
    log_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({o_mem_syn, o_ack_i, o_ack_d, o_err, o_owner, o_mem_we} !== 6'b0 ||
        o_mem_addr !== 32'h0 || o_data_i !== 32'h0 || o_rdata_d !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got syn=%0b acki=%0b ackd=%0b err=%0b own=%0b addr=%h, want all 0",
               o_mem_syn, o_ack_i, o_ack_d, o_err, o_owner, o_mem_addr);
    end
    $display("test_reset: outputs checked");
  endtask

  task automatic test_fetch_basic();
    int acks_i = 0, acks_d = 0;
    bit seen_syn = 0;
    apply_reset();
    mem_dev[32'h10] = 32'hA0A0_A0A0;
    forced_ack_at = 2;
    @(negedge a_clk);
    i_syn_i = 1; i_addr_i = 32'h10;
    for (int c = 0; c < 15; c++) begin
      @(negedge a_clk);
      if (o_mem_syn && !seen_syn) begin
        seen_syn = 1;
        total++;
        if (o_mem_addr !== 32'h10 || o_mem_we !== 1'b0 || o_mem_sel !== 4'hF || o_owner !== 1'b0) begin
          bad++;
          $display("FAIL fetch_req: got addr=%h we=%0b sel=%h own=%0b, want 10/0/f/0",
                   o_mem_addr, o_mem_we, o_mem_sel, o_owner);
        end
      end
      if (o_ack_d) acks_d++;
      if (o_ack_i) begin
        acks_i++;
        i_syn_i = 0;
        total++;
        if (o_data_i !== 32'hA0A0_A0A0) begin
          bad++;
          $display("FAIL fetch_data: got %h want a0a0a0a0", o_data_i);
        end
      end
    end
    total++;
    if (acks_i != 1 || acks_d != 0) begin
      bad++;
      $display("FAIL fetch_ack_count: got ack_i=%0d ack_d=%0d, want 1/0", acks_i, acks_d);
    end
    $display("test_fetch_basic: ack_i=%0d ack_d=%0d", acks_i, acks_d);
  endtask

  task automatic test_round_robin();
    bit exp_own[4];
    apply_reset();
    exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 0; exp_own[3] = 1;
    forced_ack_at = 1;
    @(negedge a_clk);
    i_syn_i = 1; i_addr_i = 32'h4;
    i_syn_d = 1; i_we_d = 1; i_addr_d = 32'h200; i_wdata_d = 32'hDEAD_BEEF; i_sel_d = 4'hF;
    for (int c = 0; c < 60 && log_q.size() < 4; c++) @(negedge a_clk);
    i_syn_i = 0; i_syn_d = 0;
    repeat (8) @(negedge a_clk);
    total++;
    if (log_q.size() < 4) begin
      bad++;
      $display("FAIL rr_grants: got %0d grants, want at least 4", log_q.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        total++;
        if (log_q[g].owner !== exp_own[g]) begin
          bad++;
          $display("FAIL rr_owner[%0d]: got %0b want %0b", g, log_q[g].owner, exp_own[g]);
        end
      end
      total++;
      if (log_q[0].addr !== 32'h4 || log_q[0].we !== 1'b0) begin
        bad++;
        $display("FAIL rr_fetch_req: got addr=%h we=%0b want 4/0", log_q[0].addr, log_q[0].we);
      end
      total++;
      if (log_q[1].addr !== 32'h200 || log_q[1].we !== 1'b1 ||
          log_q[1].wdata !== 32'hDEAD_BEEF || log_q[1].sel !== 4'hF) begin
        bad++;
        $display("FAIL rr_store_req: got addr=%h we=%0b wd=%h sel=%h want 200/1/deadbeef/f",
                 log_q[1].addr, log_q[1].we, log_q[1].wdata, log_q[1].sel);
      end
    end
    $display("test_round_robin: %0d grants logged", log_q.size());
  endtask

  task automatic test_flush();
    int acks_i = 0;
    bit flushed = 0;
    bit got = 0;
    mem_dev[32'h8]   = 32'hB1B1_B1B1;
    mem_dev[32'h100] = 32'hC2C2_C2C2;
    forced_ack_at = 3;
    @(negedge a_clk);
    i_syn_i = 1; i_addr_i = 32'h8;
    for (int c = 0; c < 15; c++) begin
      @(negedge a_clk);
      i_flush = 0;
      if (o_mem_syn && !flushed) begin
        flushed = 1;
        i_flush = 1;
        i_syn_i = 0;
      end
      if (o_ack_i) acks_i++;
    end
    total++;
    if (acks_i != 0 || !flushed) begin
      bad++;
      $display("FAIL flush_squash: got ack_i=%0d granted=%0b, want 0/1", acks_i, flushed);
    end
    forced_ack_at = 1;
    i_syn_i = 1; i_addr_i = 32'h100;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge a_clk);
      if (o_ack_i) begin
        got = 1;
        i_syn_i = 0;
      end
    end
    total++;
    if (!got || o_data_i !== 32'hC2C2_C2C2) begin
      bad++;
      $display("FAIL flush_refetch: got ack=%0b data=%h want 1/c2c2c2c2", got, o_data_i);
    end
    $display("test_flush: squashed acks=%0d refetch=%0b", acks_i, got);
  endtask

  task automatic test_ack_last_cycle();
    int errs = 0;
    bit got = 0;
    mem_dev[32'h304] = 32'h1234_5678;
    forced_ack_at = TO;
    @(negedge a_clk);
    i_syn_d = 1; i_we_d = 0; i_addr_d = 32'h304; i_sel_d = 4'hF;
    for (int c = 0; c < 20; c++) begin
      @(negedge a_clk);
      if (o_err) errs++;
      if (o_ack_d && !got) begin
        got = 1;
        i_syn_d = 0;
        total++;
        if (o_rdata_d !== 32'h1234_5678) begin
          bad++;
          $display("FAIL last_cycle_data: got %h want 12345678", o_rdata_d);
        end
      end
    end
    total++;
    if (!got || errs != 0) begin
      bad++;
      $display("FAIL last_cycle_err: got ack=%0b errs=%0d want 1/0", got, errs);
    end
    $display("test_ack_last_cycle: ack=%0b errs=%0d", got, errs);
  endtask

  task automatic test_timeout();
    int syn_cycles = 0, errs = 0;
    bit got = 0;
    forced_ack_at = 99;
    @(negedge a_clk);
    i_syn_d = 1; i_we_d = 0; i_addr_d = 32'h300; i_sel_d = 4'hF;
    for (int c = 0; c < 20; c++) begin
      @(negedge a_clk);
      if (o_mem_syn) syn_cycles++;
      if (o_err) begin
        errs++;
        i_syn_d = 0;
        total++;
        if (o_ack_d !== 1'b1 || o_rdata_d !== 32'h0) begin
          bad++;
          $display("FAIL timeout_resp: got ack_d=%0b rdata=%h want 1/0", o_ack_d, o_rdata_d);
        end
      end
    end
    total++;
    if (syn_cycles != TO || errs != 1) begin
      bad++;
      $display("FAIL timeout_len: got syn_cycles=%0d errs=%0d want %0d/1", syn_cycles, errs, TO);
    end
    forced_ack_at = 1;
    i_syn_i = 1; i_addr_i = 32'h40;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge a_clk);
      if (o_ack_i) begin
        got = 1;
        i_syn_i = 0;
      end
    end
    total++;
    if (!got || o_data_i !== dflt(32'h40)) begin
      bad++;
      $display("FAIL timeout_recover: got ack=%0b data=%h want 1/%h", got, o_data_i, dflt(32'h40));
    end
    $display("test_timeout: syn_cycles=%0d errs=%0d", syn_cycles, errs);
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    bit granted = 0;
    bit got = 0;
    forced_ack_at = 99;
    @(negedge a_clk);
    i_syn_d = 1; i_we_d = 0; i_addr_d = 32'h400; i_sel_d = 4'hF;
    for (int c = 0; c < 10 && !granted; c++) begin
      @(negedge a_clk);
      if (o_mem_syn) granted = 1;
    end
    a_rst = 1; i_syn_d = 0;
    @(negedge a_clk);
    total++;
    if ({o_mem_syn, o_ack_i, o_ack_d, o_err, o_owner} !== 5'b0 || o_mem_addr !== 32'h0 ||
        o_rdata_d !== 32'h0 || o_data_i !== 32'h0 || !granted) begin
      bad++;
      $display("FAIL reset_mid: got syn=%0b ackd=%0b err=%0b own=%0b addr=%h granted=%0b, want zeros",
               o_mem_syn, o_ack_d, o_err, o_owner, o_mem_addr, granted);
    end
    a_rst = 0;
    late_ack = 1;
    @(negedge a_clk);
    late_ack = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge a_clk);
      if (o_ack_i || o_ack_d || o_err || o_mem_syn) spurious++;
    end
    total++;
    if (spurious != 0) begin
      bad++;
      $display("FAIL late_ack_ignored: got %0d active cycles want 0", spurious);
    end
    forced_ack_at = 1;
    i_syn_i = 1; i_addr_i = 32'h44;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge a_clk);
      if (o_ack_i) begin
        got = 1;
        i_syn_i = 0;
      end
    end
    total++;
    if (!got || o_data_i !== dflt(32'h44)) begin
      bad++;
      $display("FAIL reset_recover: got ack=%0b data=%h want 1/%h", got, o_data_i, dflt(32'h44));
    end
    $display("test_reset_mid: spurious=%0d refetch=%0b", spurious, got);
  endtask

  task automatic test_random(input int rounds);
    bit          last;
    bit          ri, rd, we, own, to;
    logic [31:0] ai, ad, wd, e;
    logic [3:0]  sl;
    bit          order[$];
    int          idx;
    apply_reset();
    last = 1'b1;
    for (int r = 0; r < rounds; r++) begin
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) ri = 1;
      ai = 32'h2000 + {$urandom_range(0, 255), 2'b00};
      ad = 32'h3000 + {$urandom_range(0, 15), 2'b00};
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      sl = 4'($urandom_range(1, 15));
      order.delete();
      if (ri && rd) begin
        order.push_back(~last);
        order.push_back(last);
      end else begin
        order.push_back(rd);
      end
      last = order[order.size() - 1];
      log_q.delete();
      @(negedge a_clk);
      i_syn_i = ri; i_addr_i = ai;
      i_syn_d = rd; i_we_d = we; i_addr_d = ad; i_wdata_d = wd; i_sel_d = sl;
      idx = 0;
      for (int c = 0; c < 60 && idx < order.size(); c++) begin
        @(negedge a_clk);
        if (o_ack_i || o_ack_d) begin
          own = o_ack_d;
          to  = (cur_ack_at > TO);
          total++;
          if ((o_ack_i && o_ack_d) || own !== order[idx] || o_err !== to) begin
            bad++;
            $display("FAIL rnd_ack r=%0d: got ack_i=%0b ack_d=%0b err=%0b want owner=%0b err=%0b",
                     r, o_ack_i, o_ack_d, o_err, order[idx], to);
          end
          if (!own) begin
            e = to ? 32'h0 : rmem(ai);
            total++;
            if (o_data_i !== e) begin
              bad++;
              $display("FAIL rnd_fetch r=%0d: got %h want %h", r, o_data_i, e);
            end
            i_syn_i = 0;
          end else begin
            if (!we) begin
              e = to ? 32'h0 : rmem(ad);
              total++;
              if (o_rdata_d !== e) begin
                bad++;
                $display("FAIL rnd_load r=%0d: got %h want %h", r, o_rdata_d, e);
              end
            end else if (!to) begin
              ref_mem[ad] = merge(rmem(ad), wd, sl);
            end
            i_syn_d = 0;
          end
          idx++;
        end
      end
      i_syn_i = 0; i_syn_d = 0;
      total++;
      if (idx != order.size() || log_q.size() != order.size()) begin
        bad++;
        $display("FAIL rnd_count r=%0d: got acks=%0d grants=%0d want %0d", r, idx, log_q.size(), order.size());
      end else begin
        for (int g = 0; g < order.size(); g++) begin
          total++;
          if (log_q[g].owner !== order[g] || log_q[g].addr !== (order[g] ? ad : ai) ||
              log_q[g].we !== (order[g] ? we : 1'b0) ||
              (order[g] && we && log_q[g].wdata !== wd) ||
              log_q[g].sel !== (order[g] ? sl : 4'hF)) begin
            bad++;
            $display("FAIL rnd_req r=%0d g=%0d: got own=%0b addr=%h we=%0b sel=%h", r, g,
                     log_q[g].owner, log_q[g].addr, log_q[g].we, log_q[g].sel);
          end
        end
      end
      $display("rnd round %0d: fetch=%0b data=%0b we=%0b acks=%0d", r, ri, rd, we, idx);
      @(negedge a_clk);
    end
  endtask

  initial begin
    a_rst = 1'b1;
    i_syn_i = 0; i_addr_i = 0; i_flush = 0;
    i_syn_d = 0; i_we_d = 0; i_addr_d = 0; i_wdata_d = 0; i_sel_d = 0;
    test_reset();
    test_fetch_basic();
    test_round_robin();
    test_flush();
    test_ack_last_cycle();
    test_timeout();
    test_reset_mid();
    test_random(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
